// File: rtl/fnd_bcd_counter_mux_if.sv
// rtl/fnd_bcd_counter_mux_if.sv - control, count and FND signal bundle for the BCD counter/display
interface fnd_bcd_counter_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    EN;
   logic                    UP_DN;
   logic                    CLR;
   logic                    LOAD;
   logic [4*NUM_DIGITS-1:0] LOAD_VAL;
   logic                    BLANK_LZ;
   logic [4*NUM_DIGITS-1:0] COUNT;
   logic                    CARRY;
   logic [NUM_DIGITS-1:0]   FND_COM;
   logic [7:0]              FND_DATA;

   modport master (
      output EN, UP_DN, CLR, LOAD, LOAD_VAL, BLANK_LZ,
      input  COUNT, CARRY, FND_COM, FND_DATA
   );

   modport slave (
      input  EN, UP_DN, CLR, LOAD, LOAD_VAL, BLANK_LZ,
      output COUNT, CARRY, FND_COM, FND_DATA
   );
endinterface

// File: rtl/fnd_bcd_counter_mux.sv
// rtl/fnd_bcd_counter_mux.sv - N-digit up/down BCD counter with multiplexed 7-segment driver
module fnd_bcd_counter_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 24000000,
   parameter int SCAN_DIV   = 65536
) (
   input logic                      CLK,
   input logic                      RESET,
   fnd_bcd_counter_mux_if.slave     bus
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = 4 * NUM_DIGITS;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc;
   logic                  tick;
   logic [CW-1:0]         count_q;
   logic                  carry_q;
   logic [SW-1:0]         scan_cnt;
   logic [IW-1:0]         digit_idx;
   logic [NUM_DIGITS-1:0] fnd_com_q;
   logic [7:0]            fnd_data_q;

   logic [CW-1:0]         cnt_inc;
   logic [CW-1:0]         cnt_dec;
   logic [CW-1:0]         load_clamped;
   logic                  inc_c;
   logic                  dec_b;
   logic                  step;

   logic [3:0]            digit_sel;
   logic                  prefix_zero;
   logic                  lz_blank;
   logic [NUM_DIGITS-1:0] com_next;
   logic [7:0]            data_next;

   // Active-low segment pattern {a,b,c,d,e,f,g,dp}; dp kept dark
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'b00000011;
         4'd1:    seg7 = 8'b10011111;
         4'd2:    seg7 = 8'b00100101;
         4'd3:    seg7 = 8'b00001101;
         4'd4:    seg7 = 8'b10011001;
         4'd5:    seg7 = 8'b01001001;
         4'd6:    seg7 = 8'b01000001;
         4'd7:    seg7 = 8'b00011011;
         4'd8:    seg7 = 8'b00000001;
         4'd9:    seg7 = 8'b00001001;
         default: seg7 = 8'b11111111;
      endcase
   endfunction

   assign step = tick & bus.EN;

   // Ripple BCD increment/decrement from the least significant nibble, plus load clamping
   always_comb begin
      cnt_inc      = count_q;
      cnt_dec      = count_q;
      load_clamped = bus.LOAD_VAL;
      inc_c        = 1'b1;
      dec_b        = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (inc_c) begin
            if (count_q[4*i +: 4] >= 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               inc_c             = 1'b0;
            end
         end
         if (dec_b) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               cnt_dec[4*i +: 4] = 4'd9;
            end else begin
               cnt_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
               dec_b             = 1'b0;
            end
         end
         if (bus.LOAD_VAL[4*i +: 4] > 4'd9) begin
            load_clamped[4*i +: 4] = 4'd9;
         end
      end
   end

   // Prescaler and tick flag; CLR/LOAD restart the step interval, EN low freezes it
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (bus.CLR || bus.LOAD) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (bus.EN) begin
         tick  <= (presc == PRESC_MAX);
         presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end else begin
         tick  <= 1'b0;
      end
   end

   // Count register with CLR > LOAD > tick priority; CARRY flags the all-9s/all-0s wrap
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q <= '0;
         carry_q <= 1'b0;
      end else if (bus.CLR) begin
         count_q <= '0;
         carry_q <= 1'b0;
      end else if (bus.LOAD) begin
         count_q <= load_clamped;
         carry_q <= 1'b0;
      end else if (step) begin
         count_q <= bus.UP_DN ? cnt_inc : cnt_dec;
         carry_q <= bus.UP_DN ? inc_c : dec_b;
      end else begin
         carry_q <= 1'b0;
      end
   end

   // Free-running scan timer stepping the displayed digit every SCAN_DIV cycles
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == SCAN_MAX) begin
         scan_cnt  <= '0;
         digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
      end
   end

   // Select the current digit (digit 0 = MSD) and decide whether it is a blanked leading zero
   always_comb begin
      digit_sel   = 4'd0;
      prefix_zero = 1'b1;
      lz_blank    = 1'b0;
      com_next    = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         prefix_zero = prefix_zero & (count_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
         if (digit_idx == IW'(k)) begin
            digit_sel                 = count_q[4*(NUM_DIGITS-1-k) +: 4];
            lz_blank                  = prefix_zero && (k < NUM_DIGITS - 1);
            com_next[NUM_DIGITS-1-k]  = 1'b1;
         end
      end
      data_next = (bus.BLANK_LZ && lz_blank) ? 8'hFF : seg7(digit_sel);
   end

   // Registered FND drive, one cycle behind digit index and count
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         fnd_com_q  <= {1'b1, {(NUM_DIGITS-1){1'b0}}};
         fnd_data_q <= 8'hFF;
      end else begin
         fnd_com_q  <= com_next;
         fnd_data_q <= data_next;
      end
   end

   assign bus.COUNT    = count_q;
   assign bus.CARRY    = carry_q;
   assign bus.FND_COM  = fnd_com_q;
   assign bus.FND_DATA = fnd_data_q;
endmodule

// File: doc/fnd_bcd_counter_mux.md
Name: fnd_bcd_counter_mux

Overview:
Parametrised N-digit BCD counter with a multiplexed 7-segment (FND) driver.
- Next generation of the board's 4-digit seconds counter.
- Adds: digit count, tick rate and scan rate as parameters; up/down counting; enable, synchronous clear and parallel load; wrap/borrow pulse; leading-zero blanking.
- Sits between the board clock and the FND connector; the count value is also exported to other logic.

Parameters:
NUM_DIGITS, 4, number of BCD digits and FND commons (2..8).
TICK_DIV, 24000000, CLK cycles per count step (>=2).
SCAN_DIV, 65536, CLK cycles per displayed digit (>=2).

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-high reset.
EN  input  1  count enable; low freezes the prescaler and suppresses ticks.
UP_DN  input  1  1 = count up, 0 = count down.
CLR  input  1  synchronous clear of count and prescaler.
LOAD  input  1  synchronous parallel load.
LOAD_VAL  input  4*NUM_DIGITS  BCD load value; digit 0 (MSD) in the top nibble.
BLANK_LZ  input  1  1 = blank leading zero digits.
COUNT  output  4*NUM_DIGITS  current BCD count (registered).
CARRY  output  1  one-cycle pulse on wrap (up) or borrow (down).
FND_COM  output  NUM_DIGITS  one-hot digit select, active-high; MSB selects digit 0 (MSD).
FND_DATA  output  8  segments {a,b,c,d,e,f,g,dp}, active-low.

Behaviour:
Reset (asynchronous, active-high):
- COUNT=0, CARRY=0, prescaler=0, tick=0, scan counter=0, digit index=0.
- FND_COM = MSB set only; FND_DATA = 8'hFF (all segments off).

Prescaler:
- Counts 0..TICK_DIV-1 while EN=1, then wraps to 0.
- tick is a registered flag, high for one cycle, in the cycle after the prescaler equals TICK_DIV-1.
- With EN=0 the prescaler holds and tick is forced to 0.

Count priority per cycle: CLR > LOAD > tick.
- CLR: COUNT=0, prescaler=0, tick cleared, CARRY=0.
- LOAD: COUNT=LOAD_VAL with any nibble >9 clamped to 9; prescaler=0; tick cleared; CARRY=0.
- Tick with UP_DN=1:
  - BCD increment: the least significant digit at 9 goes to 0 and carries into the next digit, and so on up the digits.
  - All 9s goes to all 0s, with CARRY=1 for exactly that cycle.
- Tick with UP_DN=0:
  - BCD decrement: a digit at 0 goes to 9 and borrows from the next digit.
  - All 0s goes to all 9s, with CARRY=1.
- COUNT and CARRY update on the same edge; CARRY is 0 in all other cycles.
- Every digit held in COUNT is always in 0..9.

Scan:
- The scan counter runs 0..SCAN_DIV-1 continuously; it is not affected by EN, CLR or LOAD.
- When the counter equals SCAN_DIV-1, the digit index advances by 1, wrapping NUM_DIGITS-1 to 0.
- Digit k is displayed for exactly SCAN_DIV cycles.
- FND_COM and FND_DATA are registered, one cycle behind the digit index and COUNT.
- FND_COM = one-hot, with bit (NUM_DIGITS-1-index) set.

Segment encoding (active-low, dp always off = 1):
- 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001.
- 5=01001001, 6=01000001, 7=00011011, 8=00000001, 9=00001001.
- Blank = 11111111.

Leading-zero blanking:
- With BLANK_LZ=1, digit k (k<NUM_DIGITS-1) is blank when it and all more significant digits are 0.
- The least significant digit is never blanked, so a count of 0 shows "0".
- BLANK_LZ is sampled on the same cycle as the digit data.

Mode changes:
- UP_DN changes take effect on the next tick.
- RESET mid-count or mid-scan returns everything to reset values immediately.

Test Plan:
1. TICK_DIV=4, NUM_DIGITS=4, EN=1, UP_DN=1 from reset -> first tick 5 cycles after reset release; COUNT 0000 -> 0001 -> 0002, incrementing every 4 cycles.
2. LOAD 0x9998, then up ticks -> 9999, then 0000 with CARRY high for one cycle coincident with the wrap; LOAD_VAL 0x3A7F loads as 0x3979.
3. UP_DN=0 from 0x1000 -> 0999; from 0000 -> 9999 with a CARRY pulse; EN=0 mid-count -> COUNT and prescaler hold, no ticks.
4. Tick, LOAD and CLR asserted in the same cycle -> COUNT=0 and the prescaler restarts; LOAD with tick in the same cycle -> COUNT=LOAD_VAL, no increment.
5. SCAN_DIV=2, COUNT=0x0305, BLANK_LZ=1 -> FND_COM sequence 1000, 0100, 0010, 0001, each for 2 cycles; FND_DATA sequence FF, 00001101, 00000011, 01001001; with BLANK_LZ=0 the first digit shows 00000011.
6. RESET pulse mid-scan with COUNT=0x1234 -> COUNT=0, FND_COM=1000, FND_DATA=FF asynchronously; after release the first digit shows "0" when BLANK_LZ=0.
